jt7759_seq: RTL and testbench

- Sequencer that owns the control-side ROM interface of the JT7759 data block (ctrl_cs/ctrl_addr/ctrl_din/ctrl_ok).
- On a start command it:
  - reads the sample-count byte;
  - range-checks the requested sample;
  - fetches that sample's 16-bit pointer from the header table;
  - streams bytes from the sample start into a 2-entry prefetch buffer for the ADPCM decoder.
- Sits between the command/decoder logic and the data block; works the same in master (ROM) and slave (FIFO) modes.

---
 rtl/jt7759_seq.sv | 172 +++++++++++++++++
 tb/tb_jt7759_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_seq.sv
// Control-side ROM sequencer: header lookup (max byte, pointer) then byte streaming into a 2-entry prefetch buffer.
// Latency: STREAM entered 7 cycles after start with ctrl_ok high; reads stall while ctrl_ok is low or the buffer is full.
module jt7759_seq #(
    parameter int HDR_BASE = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  snum,
    output logic        busy,
    output logic        err,
    output logic [16:0] sample_addr,
    output logic        ctrl_cs,
    output logic [16:0] ctrl_addr,
    input  logic [7:0]  ctrl_din,
    input  logic        ctrl_ok,
    output logic [7:0]  dout,
    output logic        dout_ok,
    input  logic        pop
);

    typedef enum logic [2:0] {IDLE, RD_MAX, RD_HI, RD_LO, STREAM, ERR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  snum_q, snum_d;
    logic        err_q, err_d;
    logic [16:0] addr_q, addr_d;
    logic        settle_q, settle_d;
    logic [7:0]  ptr_hi_q, ptr_hi_d;
    logic [16:0] saddr_q, saddr_d;
    logic [7:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        accept, push, pop_v, idle_like;

    // The data block drops its valid flag one cycle after an address change,
    // so ctrl_ok is not trusted in the cycle after any address load.
    assign accept    = ctrl_cs && ctrl_ok && !settle_q;
    assign push      = accept && (state_q == STREAM);
    assign pop_v     = pop && (cnt_q != 2'd0);
    assign idle_like = (state_q == IDLE) || (state_q == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ERR: if (start) state_d = RD_MAX;
                RD_MAX:    if (accept) state_d = (snum_q > ctrl_din) ? ERR : RD_HI;
                RD_HI:     if (accept) state_d = RD_LO;
                RD_LO:     if (accept) state_d = STREAM;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy        = !idle_like;
        ctrl_cs     = (state_q == RD_MAX) || (state_q == RD_HI) || (state_q == RD_LO) ||
                      ((state_q == STREAM) && (cnt_q != 2'd2));
        err         = err_q;
        ctrl_addr   = addr_q;
        sample_addr = saddr_q;
        dout        = buf0_q;
        dout_ok     = (cnt_q != 2'd0);
    end

    always_comb begin
        snum_d   = snum_q;
        err_d    = err_q;
        addr_d   = addr_q;
        settle_d = 1'b0;
        ptr_hi_d = ptr_hi_q;
        saddr_d  = saddr_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        cnt_d    = cnt_q;
        if (stop) begin
            cnt_d = 2'd0;
            err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ERR: if (start) begin
                    snum_d   = snum;
                    err_d    = 1'b0;
                    addr_d   = 17'd0;
                    settle_d = 1'b1;
                end
                RD_MAX: if (accept) begin
                    if (snum_q > ctrl_din) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = 17'(HDR_BASE) + {8'd0, snum_q, 1'b0};
                        settle_d = 1'b1;
                    end
                end
                RD_HI: if (accept) begin
                    ptr_hi_d = ctrl_din;
                    addr_d   = addr_q + 17'd1;
                    settle_d = 1'b1;
                end
                RD_LO: if (accept) begin
                    saddr_d  = {ptr_hi_q, ctrl_din, 1'b0};
                    addr_d   = {ptr_hi_q, ctrl_din, 1'b0};
                    settle_d = 1'b1;
                end
                STREAM: begin
                    // Simultaneous push and pop keeps the count and shifts the queue.
                    case ({push, pop_v})
                        2'b10: begin
                            if (cnt_q == 2'd0) buf0_d = ctrl_din;
                            else               buf1_d = ctrl_din;
                            cnt_d = cnt_q + 2'd1;
                        end
                        2'b01: begin
                            buf0_d = buf1_q;
                            cnt_d  = cnt_q - 2'd1;
                        end
                        2'b11: begin
                            if (cnt_q == 2'd1) begin
                                buf0_d = ctrl_din;
                            end else begin
                                buf0_d = buf1_q;
                                buf1_d = ctrl_din;
                            end
                        end
                        default: ;
                    endcase
                    if (push) begin
                        addr_d   = addr_q + 17'd1;
                        settle_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snum_q   <= 8'd0;
            err_q    <= 1'b0;
            addr_q   <= 17'd0;
            settle_q <= 1'b0;
            ptr_hi_q <= 8'd0;
            saddr_q  <= 17'd0;
            buf0_q   <= 8'd0;
            buf1_q   <= 8'd0;
            cnt_q    <= 2'd0;
        end else begin
            snum_q   <= snum_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            ptr_hi_q <= ptr_hi_d;
            saddr_q  <= saddr_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jt7759_seq.sv
// Directed bench for jt7759_seq against a byte ROM with a known fill pattern.
module tb_jt7759_seq;
    logic        clk = 1'b0;
    logic        rst, start, stop, pop, ctrl_ok;
    logic [7:0]  snum, ctrl_din, dout;
    logic        busy, err, ctrl_cs, dout_ok;
    logic [16:0] sample_addr, ctrl_addr;
    logic [7:0]  rom [0:131071];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign ctrl_din = rom[ctrl_addr];

    jt7759_seq #(.HDR_BASE(5)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .snum(snum),
        .busy(busy), .err(err), .sample_addr(sample_addr),
        .ctrl_cs(ctrl_cs), .ctrl_addr(ctrl_addr), .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok),
        .dout(dout), .dout_ok(dout_ok), .pop(pop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; pop = 1'b0; ctrl_ok = 1'b1; snum = 8'd0;
        tick(); tick();
        checks++;
        if ({busy, err, ctrl_cs, dout_ok} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {busy, err, ctrl_cs, dout_ok});
        end
        checks++;
        if ({ctrl_addr, sample_addr, dout} !== 42'd0) begin
            errors++; $display("FAIL reset_values: addr %h saddr %h dout %h want all 0", ctrl_addr, sample_addr, dout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        snum = 8'd0; start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({ctrl_cs, busy} !== 2'b11 || ctrl_addr !== 17'h00000) begin
            errors++; $display("FAIL basic_rdmax: cs %b busy %b addr %h want 1 1 00000", ctrl_cs, busy, ctrl_addr);
        end
        tick();
        checks++;
        if (ctrl_addr !== 17'h00000) begin errors++; $display("FAIL basic_settle: addr %h want 00000", ctrl_addr); end
        tick();
        checks++;
        if (ctrl_addr !== 17'h00005) begin errors++; $display("FAIL basic_hi_addr: addr %h want 00005", ctrl_addr); end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h00006) begin errors++; $display("FAIL basic_lo_addr: addr %h want 00006", ctrl_addr); end
        tick(); tick();
        checks++;
        if (sample_addr !== 17'h02468 || ctrl_addr !== 17'h02468 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_stream_entry: saddr %h addr %h busy %b want 02468 02468 1", sample_addr, ctrl_addr, busy);
        end
        tick(); tick();
        checks++;
        if (dout_ok !== 1'b1 || dout !== 8'hCD || ctrl_addr !== 17'h02469) begin
            errors++; $display("FAIL basic_first_byte: ok %b dout %h addr %h want 1 cd 02469", dout_ok, dout, ctrl_addr);
        end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h0246A || ctrl_cs !== 1'b0) begin
            errors++; $display("FAIL basic_full: addr %h cs %b want 0246a 0", ctrl_addr, ctrl_cs);
        end
        repeat (4) tick();
        checks++;
        if (ctrl_addr !== 17'h0246A || dout !== 8'hCD || ctrl_cs !== 1'b0) begin
            errors++; $display("FAIL basic_hold_full: addr %h dout %h cs %b want 0246a cd 0", ctrl_addr, dout, ctrl_cs);
        end
    endtask

    task automatic test_stream_pop();
        int          got;
        logic [16:0] pa, ea;
        logic        pok;
        got = 0; pok = 1'b1; pa = ctrl_addr;
        for (int i = 0; i < 80 && got < 8; i++) begin
            if (!pok) begin
                checks++;
                if (ctrl_addr !== pa) begin errors++; $display("FAIL pop_stall_hold: addr %h want %h", ctrl_addr, pa); end
            end
            pa = ctrl_addr;
            if (dout_ok) begin
                ea = 17'h02468 + 17'(got);
                checks++;
                if (dout !== (ea[7:0] ^ 8'hA5)) begin
                    errors++; $display("FAIL pop_byte%0d: dout %h want %h", got, dout, ea[7:0] ^ 8'hA5);
                end
                got++;
                pop = 1'b1;
            end else begin
                pop = 1'b0;
            end
            ctrl_ok = ((i % 4) != 1);
            pok = ctrl_ok;
            tick();
        end
        pop = 1'b0; ctrl_ok = 1'b1;
        checks++;
        if (got != 8) begin errors++; $display("FAIL pop_count: got %0d bytes want 8", got); end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if ({busy, dout_ok, ctrl_cs} !== 3'b000) begin
            errors++; $display("FAIL pop_stop: busy/ok/cs %b want 000", {busy, dout_ok, ctrl_cs});
        end
    endtask

    task automatic test_err_wrap();
        snum = 8'd4; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        checks++;
        if ({err, busy, ctrl_cs} !== 3'b100) begin
            errors++; $display("FAIL err_set: err/busy/cs %b want 100", {err, busy, ctrl_cs});
        end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h00000 || err !== 1'b1) begin
            errors++; $display("FAIL err_hold: addr %h err %b want 00000 1", ctrl_addr, err);
        end
        snum = 8'd1; start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({err, busy} !== 2'b01) begin errors++; $display("FAIL err_clear: err/busy %b want 01", {err, busy}); end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h00007) begin errors++; $display("FAIL err_hi_addr: addr %h want 00007", ctrl_addr); end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h00008) begin errors++; $display("FAIL err_lo_addr: addr %h want 00008", ctrl_addr); end
        tick(); tick();
        checks++;
        if (sample_addr !== 17'h1FFFE || ctrl_addr !== 17'h1FFFE) begin
            errors++; $display("FAIL wrap_entry: saddr %h addr %h want 1fffe 1fffe", sample_addr, ctrl_addr);
        end
        tick(); tick();
        checks++;
        if (dout !== 8'h5B || ctrl_addr !== 17'h1FFFF) begin
            errors++; $display("FAIL wrap_b0: dout %h addr %h want 5b 1ffff", dout, ctrl_addr);
        end
        tick(); tick();
        checks++;
        if (ctrl_addr !== 17'h00000 || ctrl_cs !== 1'b0) begin
            errors++; $display("FAIL wrap_addr0: addr %h cs %b want 00000 0", ctrl_addr, ctrl_cs);
        end
        pop = 1'b1; tick(); pop = 1'b0;
        checks++;
        if (dout !== 8'h5A || ctrl_cs !== 1'b1) begin
            errors++; $display("FAIL wrap_b1: dout %h cs %b want 5a 1", dout, ctrl_cs);
        end
        tick();
        checks++;
        if (ctrl_addr !== 17'h00001) begin errors++; $display("FAIL wrap_reraise: addr %h want 00001", ctrl_addr); end
        pop = 1'b1; tick(); pop = 1'b0;
        checks++;
        if (dout !== 8'h03) begin errors++; $display("FAIL wrap_b2: dout %h want 03", dout); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_stop_rdhi();
        snum = 8'd0; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if ({busy, ctrl_cs, dout_ok} !== 3'b000 || ctrl_addr !== 17'h00005 || sample_addr !== 17'h1FFFE) begin
            errors++; $display("FAIL stop_rdhi: busy/cs/ok %b addr %h saddr %h want 000 00005 1fffe",
                               {busy, ctrl_cs, dout_ok}, ctrl_addr, sample_addr);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || ctrl_addr !== 17'h00005) begin
            errors++; $display("FAIL stop_rdhi_idle: busy %b addr %h want 0 00005", busy, ctrl_addr);
        end
    endtask

    task automatic test_start_in_stream();
        snum = 8'd0; start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        checks++;
        if (ctrl_addr !== 17'h02468) begin errors++; $display("FAIL busy_start_entry: addr %h want 02468", ctrl_addr); end
        snum = 8'd2; start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ctrl_addr !== 17'h02468 || sample_addr !== 17'h02468) begin
            errors++; $display("FAIL busy_start_ignored: busy %b addr %h saddr %h want 1 02468 02468", busy, ctrl_addr, sample_addr);
        end
        tick(); tick(); tick();
        checks++;
        if (ctrl_cs !== 1'b0 || dout_ok !== 1'b1 || ctrl_addr !== 17'h0246A) begin
            errors++; $display("FAIL busy_start_fill: cs %b ok %b addr %h want 0 1 0246a", ctrl_cs, dout_ok, ctrl_addr);
        end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({busy, err, ctrl_cs, dout_ok} !== 4'b0000 || {ctrl_addr, sample_addr, dout} !== 42'd0) begin
            errors++; $display("FAIL rst_mid: flags %b addr %h saddr %h dout %h want 0000 0 0 0",
                               {busy, err, ctrl_cs, dout_ok}, ctrl_addr, sample_addr, dout);
        end
        snum = 8'd0; start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        checks++;
        if (sample_addr !== 17'h02468 || ctrl_addr !== 17'h02468) begin
            errors++; $display("FAIL rst_restart: saddr %h addr %h want 02468 02468", sample_addr, ctrl_addr);
        end
        tick(); tick();
        checks++;
        if (dout_ok !== 1'b1 || dout !== 8'hCD) begin
            errors++; $display("FAIL rst_restart_byte: ok %b dout %h want 1 cd", dout_ok, dout);
        end
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) rom[a] = a[7:0] ^ 8'hA5;
        rom[0] = 8'h03;
        rom[5] = 8'h12;
        rom[6] = 8'h34;
        rom[7] = 8'hFF;
        rom[8] = 8'hFF;
        test_reset();
        test_basic();
        test_stream_pop();
        test_err_wrap();
        test_stop_rdhi();
        test_start_in_stream();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
